// File: rtl/alu_decoder_mc_pkg.sv
// Shared definitions for the multi-cycle ALU decoder: ALU control codes,
// alu_op codes, funct7 classes, FSM states and the decode result bundle.
package alu_decoder_mc_pkg;

    typedef logic [4:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD    = 5'd0;
    localparam alu_ctrl_t ALU_SUB    = 5'd1;
    localparam alu_ctrl_t ALU_AND    = 5'd2;
    localparam alu_ctrl_t ALU_OR     = 5'd3;
    localparam alu_ctrl_t ALU_XOR    = 5'd4;
    localparam alu_ctrl_t ALU_SLT    = 5'd5;
    localparam alu_ctrl_t ALU_SLTU   = 5'd6;
    localparam alu_ctrl_t ALU_SLL    = 5'd7;
    localparam alu_ctrl_t ALU_SRL    = 5'd8;
    localparam alu_ctrl_t ALU_SRA    = 5'd9;
    localparam alu_ctrl_t ALU_MUL    = 5'd10;
    localparam alu_ctrl_t ALU_MULH   = 5'd11;
    localparam alu_ctrl_t ALU_MULHSU = 5'd12;
    localparam alu_ctrl_t ALU_MULHU  = 5'd13;
    localparam alu_ctrl_t ALU_DIV    = 5'd14;
    localparam alu_ctrl_t ALU_DIVU   = 5'd15;
    localparam alu_ctrl_t ALU_REM    = 5'd16;
    localparam alu_ctrl_t ALU_REMU   = 5'd17;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_ARITH  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULTI = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        alu_ctrl_t ctrl;
        logic      illegal;
        logic      is_mul;
        logic      is_div;
    } dec_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic f7_is_known(input logic [6:0] f7);
        return (f7 == F7_BASE) || (f7 == F7_ALT) || (f7 == F7_MULDIV);
    endfunction

endpackage

// File: rtl/alu_decoder_mc_decode_comb.sv
// Pure combinational decode of {alu_op, funct3, funct7, op5} into an ALU
// control code plus illegal / mul / div classification.
module alu_decode_comb
    import alu_decoder_mc_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [1:0] alu_op_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic       op5_in,
    output dec_t       dec_out
);

    always_comb begin
        dec_out      = '0;
        dec_out.ctrl = ALU_ADD;
        case (alu_op_in)
            ALUOP_MEM:    dec_out.ctrl = ALU_ADD;
            ALUOP_BRANCH: dec_out.ctrl = ALU_SUB;
            ALUOP_ARITH: begin
                if (op5_in && (funct7_in == F7_MULDIV)) begin
                    if (EN_M) begin
                        // RV32M codes are laid out contiguously in funct3 order
                        dec_out.ctrl   = ALU_MUL + {2'b00, funct3_in};
                        dec_out.is_mul = ~funct3_in[2];
                        dec_out.is_div = funct3_in[2];
                    end else begin
                        dec_out.illegal = 1'b1;
                    end
                end else if (op5_in && !f7_is_known(funct7_in)) begin
                    dec_out.illegal = 1'b1;
                end else begin
                    case (funct3_in)
                        3'b000:  dec_out.ctrl = (op5_in && funct7_in[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  dec_out.ctrl = ALU_SLL;
                        3'b010:  dec_out.ctrl = ALU_SLT;
                        3'b011:  dec_out.ctrl = ALU_SLTU;
                        3'b100:  dec_out.ctrl = ALU_XOR;
                        3'b101:  dec_out.ctrl = funct7_in[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  dec_out.ctrl = ALU_OR;
                        default: dec_out.ctrl = ALU_AND;
                    endcase
                end
            end
            default: dec_out.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_decoder_mc.sv
// Registered ALU decoder with valid/ready handshake; mul/div results are held
// back for a configurable latency while busy_out stalls the datapath.
module alu_decoder_mc
    import alu_decoder_mc_pkg::*;
#(
    parameter int CTRL_W  = 5,
    parameter bit EN_M    = 1'b1,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [1:0]        alu_op_in,
    input  logic [2:0]        funct3_in,
    input  logic [6:0]        funct7_in,
    input  logic              op5_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CTRL_W-1:0] alu_control_out,
    output logic              illegal_out,
    output logic              busy_out
);

    localparam int unsigned MAX_LAT = max_u(MUL_LAT, DIV_LAT);
    localparam int          CNT_W   = $clog2(MAX_LAT + 1);
    localparam bit          MUL_MULTI = (MUL_LAT > 1);
    localparam bit          DIV_MULTI = (DIV_LAT > 1);
    // One cycle is spent entering MULTI and one leaving it, hence LAT-2
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_MULTI ? MUL_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_MULTI ? DIV_LAT - 2 : 0);

    dec_t             dec;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_ctrl_t        ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;
    logic             live_q, live_d;
    logic             accept;

    alu_decode_comb #(
        .EN_M(EN_M)
    ) u_decode (
        .alu_op_in (alu_op_in),
        .funct3_in (funct3_in),
        .funct7_in (funct7_in),
        .op5_in    (op5_in),
        .dec_out   (dec)
    );

    // live_q keeps ready_out low until the first clock after reset release
    assign live_d = 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        ready_out = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: ready_out = live_q;
            ST_MULTI: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                ready_out = ready_in;
                if (ready_in && !valid_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        accept = valid_in & ready_out;
        if (accept) begin
            ctrl_d    = dec.ctrl;
            illegal_d = dec.illegal;
            state_d   = ST_HOLD;
            if (dec.is_mul && MUL_MULTI) begin
                state_d = ST_MULTI;
                cnt_d   = MUL_CNT_INIT;
            end else if (dec.is_div && DIV_MULTI) begin
                state_d = ST_MULTI;
                cnt_d   = DIV_CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ctrl_q    <= ALU_ADD;
            illegal_q <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            live_q    <= live_d;
        end
    end

    assign valid_out       = (state_q == ST_HOLD);
    assign busy_out        = (state_q == ST_MULTI);
    assign alu_control_out = CTRL_W'(ctrl_q);
    assign illegal_out     = illegal_q;

endmodule

// File: tb/tb_alu_decoder_mc.sv
// Directed self-checking bench: one RV32M-enabled decoder and one EN_M=0 build
// driven from the same inputs.
module tb_alu_decoder_mc;

    logic       clk;
    logic       reset_n;
    logic       valid_in;
    logic       ready_in;
    logic [1:0] alu_op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       op5;

    logic       ready_out, valid_out, illegal_out, busy_out;
    logic [4:0] ctrl_out;
    logic       ready_out_n, valid_out_n, illegal_out_n, busy_out_n;
    logic [4:0] ctrl_out_n;

    int n_checks = 0;
    int n_fail   = 0;

    alu_decoder_mc #(.CTRL_W(5), .EN_M(1'b1), .MUL_LAT(3), .DIV_LAT(32)) u_dut (
        .clk_in(clk), .reset_n_in(reset_n), .valid_in(valid_in), .ready_out(ready_out),
        .alu_op_in(alu_op), .funct3_in(funct3), .funct7_in(funct7), .op5_in(op5),
        .valid_out(valid_out), .ready_in(ready_in), .alu_control_out(ctrl_out),
        .illegal_out(illegal_out), .busy_out(busy_out)
    );

    alu_decoder_mc #(.CTRL_W(5), .EN_M(1'b0), .MUL_LAT(3), .DIV_LAT(32)) u_dut_nom (
        .clk_in(clk), .reset_n_in(reset_n), .valid_in(valid_in), .ready_out(ready_out_n),
        .alu_op_in(alu_op), .funct3_in(funct3), .funct7_in(funct7), .op5_in(op5),
        .valid_out(valid_out_n), .ready_in(ready_in), .alu_control_out(ctrl_out_n),
        .illegal_out(illegal_out_n), .busy_out(busy_out_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic o5);
        alu_op = op;
        funct3 = f3;
        funct7 = f7;
        op5    = o5;
    endtask

    // Present one op, confirm it is accepted, and check the result one cycle later
    task automatic issue_base(input string tag, input logic [1:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic o5,
                              input logic [4:0] exp_ctrl, input logic exp_ill);
        drive(op, f3, f7, o5);
        valid_in = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(ready_out), 32'd1);
        tick();
        valid_in = 1'b0;
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_ctrl"}, 32'(ctrl_out), 32'(exp_ctrl));
        chk({tag, "_ill"}, 32'(illegal_out), 32'(exp_ill));
        $display("txn %s ctrl=%0d illegal=%0b", tag, ctrl_out, illegal_out);
    endtask

    task automatic issue_multi(input string tag, input logic [2:0] f3, input int lat,
                               input logic [4:0] exp_ctrl);
        drive(2'b10, f3, 7'b0000001, 1'b1);
        valid_in = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(ready_out), 32'd1);
        tick();
        valid_in = 1'b0;
        for (int k = 1; k < lat; k++) begin
            chk({tag, "_busy"}, 32'(busy_out), 32'd1);
            chk({tag, "_notready"}, 32'(ready_out), 32'd0);
            chk({tag, "_novalid"}, 32'(valid_out), 32'd0);
            tick();
        end
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_busydone"}, 32'(busy_out), 32'd0);
        chk({tag, "_ctrl"}, 32'(ctrl_out), 32'(exp_ctrl));
        chk({tag, "_ill"}, 32'(illegal_out), 32'd0);
        $display("txn %s ctrl=%0d latency=%0d", tag, ctrl_out, lat);
        tick();
        chk({tag, "_drained"}, 32'(valid_out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        drive(2'b00, 3'b000, 7'b0000000, 1'b0);
        #3;
        chk("rst_ready", 32'(ready_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_ctrl", 32'(ctrl_out), 32'd0);
        chk("rst_ill", 32'(illegal_out), 32'd0);
        tick();
        chk("rst_ready_held", 32'(ready_out), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel_ready_pre", 32'(ready_out), 32'd0);
        tick();
        chk("rel_ready", 32'(ready_out), 32'd1);

        // load/store and branch
        issue_base("add_mem", 2'b00, 3'b111, 7'b0100000, 1'b1, 5'd0, 1'b0);
        issue_base("sub_br", 2'b01, 3'b101, 7'b1111111, 1'b1, 5'd1, 1'b0);
        tick();
        chk("idle_after_br", 32'(valid_out), 32'd0);

        // R/I-type sweep
        issue_base("r_sub", 2'b10, 3'b000, 7'b0100000, 1'b1, 5'd1, 1'b0);
        issue_base("r_sra", 2'b10, 3'b101, 7'b0100000, 1'b1, 5'd9, 1'b0);
        issue_base("r_slt", 2'b10, 3'b010, 7'b0000000, 1'b1, 5'd5, 1'b0);
        issue_base("r_sltu", 2'b10, 3'b011, 7'b0000000, 1'b1, 5'd6, 1'b0);
        issue_base("r_or", 2'b10, 3'b110, 7'b0000000, 1'b1, 5'd3, 1'b0);
        issue_base("r_and", 2'b10, 3'b111, 7'b0000000, 1'b1, 5'd2, 1'b0);
        issue_base("r_srl", 2'b10, 3'b101, 7'b0000000, 1'b1, 5'd8, 1'b0);
        issue_base("i_addi", 2'b10, 3'b000, 7'b0100000, 1'b0, 5'd0, 1'b0);
        issue_base("i_slli", 2'b10, 3'b001, 7'b0000000, 1'b0, 5'd7, 1'b0);
        issue_base("i_xori", 2'b10, 3'b100, 7'b1010101, 1'b0, 5'd4, 1'b0);

        // illegal encodings
        issue_base("ill_op11", 2'b11, 3'b010, 7'b0000000, 1'b1, 5'd0, 1'b1);
        issue_base("ill_f7", 2'b10, 3'b100, 7'b1111111, 1'b1, 5'd0, 1'b1);
        issue_base("after_ill", 2'b10, 3'b001, 7'b0000000, 1'b1, 5'd7, 1'b0);
        tick();
        chk("idle_before_m", 32'(valid_out), 32'd0);

        // DIV: the EN_M=0 build flags it illegal with 1-cycle latency
        drive(2'b10, 3'b100, 7'b0000001, 1'b1);
        valid_in = 1'b1;
        #1;
        chk("div_ready", 32'(ready_out), 32'd1);
        tick();
        valid_in = 1'b0;
        chk("nom_div_valid", 32'(valid_out_n), 32'd1);
        chk("nom_div_ctrl", 32'(ctrl_out_n), 32'd0);
        chk("nom_div_ill", 32'(illegal_out_n), 32'd1);
        chk("nom_div_busy", 32'(busy_out_n), 32'd0);
        $display("txn nom_div ctrl=%0d illegal=%0b", ctrl_out_n, illegal_out_n);
        for (int k = 1; k < 32; k++) begin
            chk("div_busy", 32'(busy_out), 32'd1);
            chk("div_notready", 32'(ready_out), 32'd0);
            chk("div_novalid", 32'(valid_out), 32'd0);
            tick();
        end
        chk("div_valid", 32'(valid_out), 32'd1);
        chk("div_busydone", 32'(busy_out), 32'd0);
        chk("div_ctrl", 32'(ctrl_out), 32'd14);
        chk("div_ill", 32'(illegal_out), 32'd0);
        $display("txn div ctrl=%0d latency=32", ctrl_out);
        tick();
        chk("div_drained", 32'(valid_out), 32'd0);

        issue_multi("mul", 3'b000, 3, 5'd10);
        issue_multi("mulhu", 3'b011, 3, 5'd13);
        issue_multi("remu", 3'b111, 32, 5'd17);

        // Backpressure: first result held, second op waits then goes through once
        ready_in = 1'b0;
        drive(2'b10, 3'b100, 7'b0000000, 1'b1);
        valid_in = 1'b1;
        tick();
        drive(2'b01, 3'b000, 7'b0000000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", 32'(valid_out), 32'd1);
            chk("bp_ctrl", 32'(ctrl_out), 32'd4);
            chk("bp_notready", 32'(ready_out), 32'd0);
            tick();
        end
        ready_in = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(ready_out), 32'd1);
        tick();
        valid_in = 1'b0;
        chk("bp_second_valid", 32'(valid_out), 32'd1);
        chk("bp_second_ctrl", 32'(ctrl_out), 32'd1);
        $display("txn bp_second ctrl=%0d", ctrl_out);
        tick();
        chk("bp_no_dup", 32'(valid_out), 32'd0);

        // Reset in the middle of a DIV
        drive(2'b10, 3'b101, 7'b0000001, 1'b1);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        chk("mid_busy", 32'(busy_out), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy_out), 32'd0);
        chk("mr_valid", 32'(valid_out), 32'd0);
        chk("mr_ready", 32'(ready_out), 32'd0);
        chk("mr_ctrl", 32'(ctrl_out), 32'd0);
        chk("mr_ill", 32'(illegal_out), 32'd0);
        $display("txn mid_div_reset busy=%0b valid=%0b", busy_out, valid_out);
        tick();
        reset_n = 1'b1;
        tick();
        chk("mr_rel_ready", 32'(ready_out), 32'd1);
        issue_base("mr_add", 2'b00, 3'b000, 7'b0000000, 1'b0, 5'd0, 1'b0);
        issue_base("mr_sub", 2'b01, 3'b000, 7'b0000000, 1'b0, 5'd1, 1'b0);
        tick();
        chk("mr_idle", 32'(busy_out | valid_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
